// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution step controller.
// Holds the FSM state encoding, the default halt opcode and the default widths/rates.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } exec_state_t;

    localparam logic [5:0]  DEFAULT_HALT_OP = 6'b111111;
    localparam int unsigned STEP_CNT_W      = 16;
    localparam int unsigned DEFAULT_RUN_DIV = 1000;

endpackage

// File: rtl/rate_divider.sv
// Free-running modulo-RUN_DIV counter that paces free-run execution.
// tick is high for the single cycle in which the count sits at RUN_DIV-1.
module rate_divider #(
    parameter int unsigned RUN_DIV = 1000
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(RUN_DIV - 1);

    logic [DIV_W-1:0] count;

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/exec_step_controller.sv
// Step sequencer for the single-cycle CPU: manual single-step, paced free-run and halt detection.
// Optional breakpoint support is compiled in when EXEC_BREAKPOINT_EN is defined.
module exec_step_controller
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DIV = DEFAULT_RUN_DIV,
    parameter int unsigned CNT_W   = STEP_CNT_W,
    parameter logic [5:0]  HALT_OP = DEFAULT_HALT_OP
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             key_pulse,
    input  logic             run_sel,
    input  logic [5:0]       op,
    input  logic [31:0]      pc,
`ifdef EXEC_BREAKPOINT_EN
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             bp_hit,
`endif
    output logic             step_en,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_count
);

    exec_state_t state_q;
    exec_state_t state_d;
    logic        pulse_d;
    logic        tick;
    logic        bp_take;

    // Divider is held at zero outside RUN so every entry starts a fresh RUN_DIV interval.
    rate_divider #(
        .RUN_DIV (RUN_DIV)
    ) u_rate_divider (
        .clk  (clk),
        .clr  (RST | (state_q != RUN)),
        .tick (tick)
    );

`ifdef EXEC_BREAKPOINT_EN
    logic first_decision;

    assign bp_take = (state_q == RUN) && run_sel && !key_pulse && tick &&
                     bp_valid && (pc == bp_addr) && !first_decision;

    // The first decision point after entering RUN skips the breakpoint so resume makes progress.
    always_ff @(posedge clk) begin
        if (RST) begin
            first_decision <= 1'b1;
            bp_hit         <= 1'b0;
        end else begin
            if (state_q != RUN) begin
                first_decision <= 1'b1;
            end else if (tick) begin
                first_decision <= 1'b0;
            end
            if (bp_take) begin
                bp_hit <= 1'b1;
            end else if (key_pulse) begin
                bp_hit <= 1'b0;
            end
        end
    end
`else
    logic unused_pc;

    assign bp_take   = 1'b0;
    assign unused_pc = ^pc;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_pulse) begin
                    if (run_sel) begin
                        state_d = RUN;
                    end else if (op == HALT_OP) begin
                        state_d = HALT;
                    end else begin
                        state_d = STEP;
                        pulse_d = 1'b1;
                    end
                end
            end
            STEP: state_d = IDLE;
            RUN: begin
                // A pause request outranks the decision point: no pulse is issued.
                if (key_pulse || !run_sel) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (bp_take) begin
                        state_d = IDLE;
                    end else if (op == HALT_OP) begin
                        state_d = HALT;
                    end else begin
                        pulse_d = 1'b1;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            step_en    <= 1'b0;
            halted     <= 1'b0;
            step_count <= '0;
        end else begin
            state_q <= state_d;
            step_en <= pulse_d;
            halted  <= (state_d == HALT);
            if (pulse_d && (step_count != '1)) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Self-checking bench for exec_step_controller: directed scenarios with literal expectations
// plus randomized stimulus compared every cycle against a cycle-arithmetic reference model.
module tb_exec_step_controller;

    localparam int unsigned RUN_DIV = 4;
    localparam int unsigned CNT_W   = 4;
    localparam logic [5:0]  HALT_OP = 6'b111111;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    localparam int ST_IDLE = 0;
    localparam int ST_STEP = 1;
    localparam int ST_RUN  = 2;
    localparam int ST_HALT = 3;

    logic             clk = 1'b0;
    logic             RST;
    logic             key_pulse;
    logic             run_sel;
    logic [5:0]       op;
    logic [31:0]      pc;
    logic             step_en;
    logic             halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] step_count;
`ifdef EXEC_BREAKPOINT_EN
    logic [31:0]      bp_addr;
    logic             bp_valid;
    logic             bp_hit;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_step_controller #(
        .RUN_DIV (RUN_DIV),
        .CNT_W   (CNT_W),
        .HALT_OP (HALT_OP)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .key_pulse  (key_pulse),
        .run_sel    (run_sel),
        .op         (op),
        .pc         (pc),
`ifdef EXEC_BREAKPOINT_EN
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .bp_hit     (bp_hit),
`endif
        .step_en    (step_en),
        .halted     (halted),
        .state      (state),
        .step_count (step_count)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a RUN session started at edge run_t0 makes a decision in every cycle
    // whose distance from run_t0 is RUN_DIV-1 modulo RUN_DIV.
    int edge_n      = 0;
    bit model_valid = 1'b0;
    int m_state     = ST_IDLE;
    bit m_step      = 1'b0;
    bit m_halt      = 1'b0;
    bit m_bp        = 1'b0;
    int m_pulses    = 0;
    int run_t0      = 0;

    always @(posedge clk) begin
        bit decide;
        bit bp_stop;
        edge_n++;
        if (RST === 1'b1) begin
            m_state     = ST_IDLE;
            m_step      = 1'b0;
            m_halt      = 1'b0;
            m_bp        = 1'b0;
            m_pulses    = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            decide  = (m_state == ST_RUN) &&
                      (((edge_n - 1 - run_t0) % RUN_DIV) == RUN_DIV - 1);
            bp_stop = 1'b0;
            m_step  = 1'b0;
            if (key_pulse) m_bp = 1'b0;
            case (m_state)
                ST_IDLE: begin
                    if (key_pulse) begin
                        if (run_sel) begin
                            m_state = ST_RUN;
                            run_t0  = edge_n;
                        end else if (op == HALT_OP) begin
                            m_state = ST_HALT;
                        end else begin
                            m_state = ST_STEP;
                            m_step  = 1'b1;
                        end
                    end
                end
                ST_STEP: m_state = ST_IDLE;
                ST_RUN: begin
                    if (key_pulse || !run_sel) begin
                        m_state = ST_IDLE;
                    end else if (decide) begin
`ifdef EXEC_BREAKPOINT_EN
                        bp_stop = bp_valid && (pc == bp_addr) &&
                                  ((edge_n - 1 - run_t0) != RUN_DIV - 1);
`endif
                        if (bp_stop) begin
                            m_state = ST_IDLE;
                            m_bp    = 1'b1;
                        end else if (op == HALT_OP) begin
                            m_state = ST_HALT;
                        end else begin
                            m_step = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (m_step) m_pulses++;
            m_halt = (m_state == ST_HALT);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_step_en", step_en, m_step);
            check("model_state", state, m_state);
            check("model_halted", halted, m_halt);
            check("model_step_count", step_count, (m_pulses > CNT_MAX) ? CNT_MAX : m_pulses);
`ifdef EXEC_BREAKPOINT_EN
            check("model_bp_hit", bp_hit, m_bp);
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk);
        RST       = 1'b1;
        key_pulse = 1'b0;
        run_sel   = 1'b0;
        op        = 6'd0;
        pc        = 32'd0;
`ifdef EXEC_BREAKPOINT_EN
        bp_valid  = 1'b0;
        bp_addr   = 32'd0;
`endif
        @(negedge clk);
        RST = 1'b0;
    endtask

    int pulse_offs[$];

    initial begin
        RST       = 1'b1;
        key_pulse = 1'b0;
        run_sel   = 1'b0;
        op        = 6'd0;
        pc        = 32'd0;
`ifdef EXEC_BREAKPOINT_EN
        bp_valid  = 1'b0;
        bp_addr   = 32'd0;
`endif
        repeat (2) @(negedge clk);

        // Reset state, then one manual step with one-cycle latency.
        do_reset();
        check("rst_state", state, ST_IDLE);
        check("rst_step_en", step_en, 0);
        check("rst_halted", halted, 0);
        check("rst_step_count", step_count, 0);
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
        check("ss_step_en", step_en, 1);
        check("ss_state_step", state, ST_STEP);
        @(negedge clk);
        check("ss_step_en_once", step_en, 0);
        check("ss_state_idle", state, ST_IDLE);
        check("ss_step_count", step_count, 1);

        // Free-run pacing: pulses 5, 9 and 13 cycles after the key cycle, then run_sel drop.
        do_reset();
        run_sel   = 1'b1;
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
        pulse_offs.delete();
        for (int off = 1; off <= 14; off++) begin
            if (step_en === 1'b1) pulse_offs.push_back(off);
            @(negedge clk);
        end
        check("run_pulse_total", pulse_offs.size(), 3);
        if (pulse_offs.size() == 3) begin
            check("run_pulse_1", pulse_offs[0], 5);
            check("run_pulse_2", pulse_offs[1], 9);
            check("run_pulse_3", pulse_offs[2], 13);
        end
        check("run_step_count", step_count, 3);
        check("run_state", state, ST_RUN);
        run_sel = 1'b0;
        @(negedge clk);
        check("runsel_drop_state", state, ST_IDLE);
        check("runsel_drop_step_en", step_en, 0);

        // A key press on the decision-point cycle pauses without a pulse.
        do_reset();
        run_sel   = 1'b1;
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
        repeat (3) @(negedge clk);
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
        check("pause_step_en", step_en, 0);
        check("pause_state", state, ST_IDLE);
        check("pause_step_count", step_count, 0);

        // Halt opcode before the second decision point; HALT ignores everything but RST.
        do_reset();
        run_sel   = 1'b1;
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
        repeat (4) @(negedge clk);
        check("halt_first_pulse", step_en, 1);
        op = HALT_OP;
        repeat (4) @(negedge clk);
        check("halt_no_pulse", step_en, 0);
        check("halt_state", state, ST_HALT);
        check("halt_flag", halted, 1);
        check("halt_step_count", step_count, 1);
        for (int i = 0; i < 6; i++) begin
            key_pulse = i[0];
            run_sel   = ~run_sel;
            op        = 6'd0;
            @(negedge clk);
        end
        key_pulse = 1'b0;
        check("halt_sticky_state", state, ST_HALT);
        check("halt_sticky_flag", halted, 1);
        check("halt_sticky_count", step_count, 1);
        do_reset();
        check("halt_rst_state", state, ST_IDLE);
        check("halt_rst_flag", halted, 0);

        // Counter saturation: 20 manual steps into a 4-bit counter.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            key_pulse = 1'b1;
            @(negedge clk);
            key_pulse = 1'b0;
            check("sat_step_en", step_en, 1);
            @(negedge clk);
            check("sat_step_count", step_count, (i > 15) ? 15 : i);
        end
        check("sat_final", step_count, 15);

`ifdef EXEC_BREAKPOINT_EN
        // Breakpoint at pc 0x0C: skipped at the first decision, taken at the second, resume steps.
        do_reset();
        bp_addr   = 32'h0000_000C;
        bp_valid  = 1'b1;
        pc        = 32'h0000_000C;
        run_sel   = 1'b1;
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_first_pulse", step_en, 1);
        repeat (4) @(negedge clk);
        check("bp_no_pulse", step_en, 0);
        check("bp_state", state, ST_IDLE);
        check("bp_hit_set", bp_hit, 1);
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
        check("bp_hit_clear", bp_hit, 0);
        check("bp_resume_state", state, ST_RUN);
        repeat (4) @(negedge clk);
        check("bp_resume_pulse", step_en, 1);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            RST       = ($urandom_range(0, 299) == 0);
            key_pulse = !key_pulse && ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) run_sel = ~run_sel;
            op = ($urandom_range(0, 79) == 0) ? HALT_OP : 6'($urandom_range(0, 62));
            pc = 32'($urandom_range(0, 3) * 4);
`ifdef EXEC_BREAKPOINT_EN
            bp_addr = 32'h0000_0008;
            if ($urandom_range(0, 29) == 0) bp_valid = ~bp_valid;
`endif
            @(negedge clk);
        end
        RST       = 1'b0;
        key_pulse = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
